// File: rtl/pi_qpsk_decode.sv
// Differential pi/4-QPSK symbol decoder: magnitude/sign capture, 8-sector
// quantisation, then a HUNT/TRACK phase-step tracker producing dibits.
module pi_qpsk_decode #(
  parameter int TAN_NUM = 106,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic signed [7:0] Xk,
  input  logic signed [7:0] Yk,
  input  logic              resync,
  output logic [1:0]        dout,
  output logic              dout_valid,
  output logic              sym_err,
  output logic              locked,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic {HUNT, TRACK} state_t;

  // |-128| must come out as 128, so the magnitude is kept unsigned 8-bit.
  function automatic logic [7:0] mag8(input logic signed [7:0] v);
    logic [7:0] u;
    u = v;
    return v[7] ? (~u + 8'd1) : u;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [2:0] sector(input logic xneg, input logic yneg,
                                        input logic [7:0] ax, input logic [7:0] ay);
    logic [17:0] ax_s, ay_s, ax_t, ay_t;
    ax_s = {2'b00, ax, 8'h00};
    ay_s = {2'b00, ay, 8'h00};
    ax_t = 18'(TAN_NUM) * {10'd0, ax};
    ay_t = 18'(TAN_NUM) * {10'd0, ay};
    if (ay_s < ax_t)
      return xneg ? 3'd4 : 3'd0;
    else if (ax_s < ay_t)
      return yneg ? 3'd6 : 3'd2;
    else begin
      case ({xneg, yneg})
        2'b00:   return 3'd1;
        2'b10:   return 3'd3;
        2'b11:   return 3'd5;
        default: return 3'd7;
      endcase
    end
  endfunction

  // Returns {sym_err, dibit}; even steps are not legal pi/4-QPSK transitions.
  function automatic logic [2:0] step_map(input logic [2:0] d);
    case (d)
      3'd1:    return 3'b0_00;
      3'd7:    return 3'b0_01;
      3'd3:    return 3'b0_10;
      3'd5:    return 3'b0_11;
      default: return 3'b1_00;
    endcase
  endfunction

  logic              vld_p1, vld_p2;
  logic              xneg_p1, yneg_p1;
  logic [7:0]        ax_p1, ay_p1;
  logic [2:0]        s_p2;

  state_t            state, state_nx;
  logic [2:0]        ref_s, ref_nx;
  logic [2:0]        d;
  logic [1:0]        dout_nx;
  logic              err_nx, vld_nx;
  logic [ERR_W-1:0]  cnt_nx;

  // Stage 1: sign and magnitude capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= din_valid;
  end

  always_ff @(posedge clk) begin
    xneg_p1 <= Xk[7];
    yneg_p1 <= Yk[7];
    ax_p1   <= mag8(Xk);
    ay_p1   <= mag8(Yk);
  end

  // Stage 2: sector quantisation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p2 <= 1'b0;
    else      vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    s_p2 <= sector(xneg_p1, yneg_p1, ax_p1, ay_p1);
  end

  // Stage 3: phase-reference tracker
  always_comb begin
    state_nx = state;
    ref_nx   = ref_s;
    dout_nx  = dout;
    err_nx   = sym_err;
    vld_nx   = 1'b0;
    cnt_nx   = err_cnt;
    d        = s_p2 - ref_s;
    if (resync) begin
      // A symbol arriving with resync re-seeds the reference instead of decoding.
      state_nx = vld_p2 ? TRACK : HUNT;
      if (vld_p2) ref_nx = s_p2;
    end else if (vld_p2) begin
      state_nx = TRACK;
      ref_nx   = s_p2;
      if (state == TRACK) begin
        vld_nx            = 1'b1;
        {err_nx, dout_nx} = step_map(d);
        if (err_nx) cnt_nx = sat_inc(err_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      ref_s      <= 3'd0;
      dout       <= 2'b00;
      sym_err    <= 1'b0;
      dout_valid <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nx;
      ref_s      <= ref_nx;
      dout       <= dout_nx;
      sym_err    <= err_nx;
      dout_valid <= vld_nx;
      err_cnt    <= cnt_nx;
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_pi_qpsk_decode.sv
// Directed bench for pi_qpsk_decode: reset, dibit mapping, sector edges,
// error saturation, bubbles, resync and an encoder loopback.
module tb_pi_qpsk_decode;

  logic              clk;
  logic              rst;
  logic              din_valid;
  logic signed [7:0] Xk, Yk;
  logic              resync;
  logic [1:0]        dout;
  logic              dout_valid;
  logic              sym_err;
  logic              locked;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pi_qpsk_decode #(.TAN_NUM(106), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .Xk(Xk), .Yk(Yk),
    .resync(resync), .dout(dout), .dout_valid(dout_valid),
    .sym_err(sym_err), .locked(locked), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic signed [7:0] qx[$], qy[$];
  logic              qv[$], qe[$];
  logic [1:0]        qd[$];

  int ptx[8] = '{127, 90, 0, -90, -127, -90, 0, 90};
  int pty[8] = '{0, 90, 127, 90, 0, -90, -127, -90};
  int stp[4] = '{1, 7, 3, 5};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int x, input int y, input logic v, input logic [1:0] dd, input logic e);
    qx.push_back(8'(x));
    qy.push_back(8'(y));
    qv.push_back(v);
    qd.push_back(dd);
    qe.push_back(e);
  endtask

  // Drives the queued symbols back-to-back and checks each one three cycles later.
  task automatic burst(input string tag);
    int n;
    n = qx.size();
    for (int c = 0; c < n + 3; c++) begin
      if (c >= 3) begin
        check({tag, " vld"}, 32'(dout_valid), 32'(qv[c-3]));
        check({tag, " locked"}, 32'(locked), 1);
        if (qv[c-3]) begin
          check({tag, " dout"}, 32'(dout), 32'(qd[c-3]));
          check({tag, " sym_err"}, 32'(sym_err), 32'(qe[c-3]));
        end
      end
      if (c < n) begin
        din_valid = 1'b1; Xk = qx[c]; Yk = qy[c];
      end else begin
        din_valid = 1'b0;
      end
      tick();
    end
    check({tag, " tail vld"}, 32'(dout_valid), 0);
    qx.delete(); qy.delete(); qv.delete(); qd.delete(); qe.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " dout_valid"}, 32'(dout_valid), 0);
    check({tag, " dout"}, 32'(dout), 0);
    check({tag, " sym_err"}, 32'(sym_err), 0);
    check({tag, " locked"}, 32'(locked), 0);
    check({tag, " err_cnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    int pulses, pulse_at, p;
    logic [1:0] last_d;
    logic [1:0] dib[2000];

    rst = 1'b0; din_valid = 1'b0; Xk = '0; Yk = '0; resync = 1'b0;
    tick(); tick();
    check_reset("reset");
    rst = 1'b1;
    tick();

    // Mapping: first symbol is the reference, then 00, 01, 10, 11.
    add(127, 0, 0, 2'd0, 0);
    add(90, 90, 1, 2'd0, 0);
    add(127, 0, 1, 2'd1, 0);
    add(-90, 90, 1, 2'd2, 0);
    add(127, 0, 1, 2'd3, 0);
    burst("map");
    check("hold dout", 32'(dout), 3);
    check("hold sym_err", 32'(sym_err), 0);

    // Wrap, -128 corner (s=5) and origin (s=1); reference is s=0 here.
    add(90, -90, 1, 2'd1, 0);
    add(127, 0, 1, 2'd0, 0);
    add(-128, -128, 1, 2'd3, 0);
    add(127, 0, 1, 2'd2, 0);
    add(0, 0, 1, 2'd0, 0);
    burst("edge");
    check("err_cnt clean", 32'(err_cnt), 0);

    // Errors: reference s=1, then s=0 (d=7) and s=2 (d=2, illegal).
    add(127, 0, 1, 2'd1, 0);
    add(0, 127, 1, 2'd0, 1);
    burst("err");
    check("err_cnt one", 32'(err_cnt), 1);
    din_valid = 1'b1; Xk = 8'sd0; Yk = 8'sd127;
    repeat (300) tick();
    din_valid = 1'b0;
    repeat (4) tick();
    check("err_cnt sat", 32'(err_cnt), 255);
    check("err hold sym_err", 32'(sym_err), 1);

    // Mid-stream reset with symbols in flight.
    din_valid = 1'b1; Xk = 8'sd127; Yk = 8'sd0;
    tick(); tick();
    #3 rst = 1'b0;
    #1 check_reset("mid reset");
    din_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    add(127, 0, 0, 2'd0, 0);
    add(90, 90, 1, 2'd0, 0);
    burst("post reset");
    check("post reset err_cnt", 32'(err_cnt), 0);

    // Resync with empty pipeline, then bubbles between reference and symbol.
    resync = 1'b1; tick(); resync = 1'b0;
    check("resync locked", 32'(locked), 0);
    pulses = 0; pulse_at = -1; last_d = 2'b11;
    for (int c = 0; c < 14; c++) begin
      din_valid = (c == 0) || (c == 6);
      Xk = (c == 0) ? 8'sd127 : 8'sd90;
      Yk = (c == 0) ? 8'sd0 : 8'sd90;
      tick();
      if (dout_valid) begin pulses++; pulse_at = c; last_d = dout; end
    end
    check("bubble pulses", 32'(pulses), 1);
    check("bubble latency", 32'(pulse_at), 8);
    check("bubble dout", 32'(last_d), 0);
    check("bubble sym_err", 32'(sym_err), 0);

    // Resync coincident with a stage-3 symbol re-seeds the reference (ref was 1).
    pulses = 0; pulse_at = -1; last_d = 2'b11;
    for (int c = 0; c < 10; c++) begin
      din_valid = (c < 2);
      Xk = (c == 0) ? -8'sd127 : -8'sd90;
      Yk = (c == 0) ? 8'sd0 : 8'sd90;
      resync = (c == 2);
      tick();
      if (dout_valid) begin pulses++; pulse_at = c; last_d = dout; end
    end
    resync = 1'b0;
    check("coinc pulses", 32'(pulses), 1);
    check("coinc latency", 32'(pulse_at), 3);
    check("coinc dout", 32'(last_d), 1);
    check("coinc locked", 32'(locked), 1);
    check("coinc err_cnt", 32'(err_cnt), 0);

    // Loopback through a pi/4-QPSK encoder model.
    rst = 1'b0; tick(); rst = 1'b1; tick();
    for (int k = 0; k < 2000; k++) dib[k] = 2'($urandom_range(0, 3));
    p = 0;
    for (int c = 0; c < 2004; c++) begin
      if (c == 3) check("loop ref", 32'(dout_valid), 0);
      if (c >= 4) check("loop dibit", {29'd0, dout_valid, dout}, {29'd0, 1'b1, dib[c-4]});
      if (c < 2001) begin
        if (c > 0) p = (p + stp[dib[c-1]]) % 8;
        din_valid = 1'b1; Xk = 8'(ptx[p]); Yk = 8'(pty[p]);
      end else begin
        din_valid = 1'b0;
      end
      tick();
    end
    check("loop err_cnt", 32'(err_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pi_qpsk_decode.md
PI_QPSK_DECODE -- requirements
Module: pi_qpsk_decode

Interface
REQ-001 SHALL have parameter TAN_NUM, default 106, the numerator over 256 approximating tan(22.5 deg) for the axis/diagonal decision.
REQ-002 SHALL have parameter ERR_W, default 8, the width of the error counter.
REQ-003 SHALL have clk, input, 1 bit: the FPGA system clock; all state changes on its rising edge.
REQ-004 SHALL have rst, input, 1 bit: reset; asynchronous, active-low.
REQ-005 SHALL have din_valid, input, 1 bit: Xk/Yk hold one received symbol this cycle.
REQ-006 SHALL have Xk, input, signed 8 bits: received in-phase sample.
REQ-007 SHALL have Yk, input, signed 8 bits: received quadrature sample.
REQ-008 SHALL have resync, input, 1 bit: synchronous request to discard the phase reference.
REQ-009 SHALL have dout, output, 2 bits: recovered dibit.
REQ-010 SHALL have dout_valid, output, 1 bit: one-cycle strobe qualifying dout and sym_err.
REQ-011 SHALL have sym_err, output, 1 bit: the phase step of the current symbol was not an odd multiple of 45 deg.
REQ-012 SHALL have locked, output, 1 bit: a phase reference is held.
REQ-013 SHALL have err_cnt, output, ERR_W bits: saturating count of sym_err events.

Function
REQ-014 SHALL accept one symbol per clock with no back-pressure; cycles with din_valid=0 are bubbles and SHALL NOT change the reference or any counter.
REQ-015 Stage 1 SHALL register din_valid, the signs of Xk and Yk, ax=|Xk| and ay=|Yk| as 8-bit unsigned values (|-128| = 128).
REQ-016 Stage 2 SHALL quantise to sector s in 0..7: x-axis when 256*ay < TAN_NUM*ax; y-axis when 256*ax < TAN_NUM*ay; diagonal otherwise.
REQ-017 For the x-axis, s SHALL be 0 when Xk>=0, else 4; for the y-axis, s SHALL be 2 when Yk>=0, else 6.
REQ-018 For a diagonal, s SHALL be 1 for (X>=0, Y>=0), 3 for (X<0, Y>=0), 5 for (X<0, Y<0), and 7 for (X>=0, Y<0); Xk=Yk=0 yields s=1.
REQ-019 Stage 3 SHALL be a 2-state FSM: HUNT (locked=0) and TRACK (locked=1).
REQ-020 In HUNT, a valid stage-2 symbol SHALL store s as ref, move the FSM to TRACK, and produce no dout_valid.
REQ-021 In TRACK, a valid symbol SHALL compute d=(s-ref) mod 8 (3-bit wrap), then set ref=s and pulse dout_valid.
REQ-022 In TRACK, d SHALL map d=1->dout 00, d=7->01, d=3->10, and d=5->11, with sym_err=0.
REQ-023 In TRACK, an even d (0,2,4,6) SHALL give dout=00 and sym_err=1, and err_cnt SHALL increment, holding at 2^ERR_W-1.
REQ-024 Latency SHALL be exactly 3 clocks from a din_valid sample to its dout_valid strobe.
REQ-025 dout and sym_err SHALL hold their last values while dout_valid=0.
REQ-026 resync=1 SHALL force the FSM to HUNT on the next edge and suppress any dout_valid that would occur that edge.
REQ-027 A stage-3 symbol coincident with resync SHALL become the new ref, leaving the FSM in TRACK with no output; err_cnt SHALL be unaffected.
REQ-028 The decoder SHALL invert the team's pi/4-QPSK encoder mapping: dibit 0 = +45 deg, 1 = -45 deg, 2 = +135 deg, 3 = -135 deg.

Reset
REQ-029 While rst=0, dout=00, dout_valid=0, sym_err=0, locked=0, err_cnt=0, ref=0, and all pipeline valids SHALL be 0, with the FSM in HUNT.
REQ-030 Reset assertion mid-stream SHALL discard in-flight symbols; the first valid symbol after release SHALL be a reference only.

Verification
REQ-031 Reset: assert rst=0 mid-stream with din_valid=1 -> all outputs 0 on the same edge, and no dout_valid for the first symbol after release.
REQ-032 Mapping: (127,0),(90,90),(127,0),(-90,90),(127,0) on consecutive cycles -> dout 00,01,10,11 at cycles 4,5,6,7 after the first sample, with sym_err=0 and locked=1 from cycle 3.
REQ-033 Wrap and edges: (90,-90) then (127,0) -> dout=00; (-128,-128) quantises to s=5; (0,0) quantises to s=1.
REQ-034 Errors: (127,0) then (0,127) -> dout=00, sym_err=1, err_cnt=1; 300 consecutive 0-deg steps -> err_cnt=255 and held there.
REQ-035 Bubbles/resync: (127,0), 5 idle cycles, then (90,90) -> single dout=00; resync between symbols -> next symbol gives no output and the following one decodes against it.
REQ-036 Loopback: 2000 random dibits through the pi/4-QPSK encoder with din_valid=1 -> decoded stream equals the input after fixed alignment, err_cnt=0.
